// File: rtl/booth_ctrl_if.sv
// Handshake and strobe bundle between the Booth sequencer and its datapath/host.
// The slave modport is the controller side and the master modport is the datapath/host side.
interface booth_ctrl_if;
    logic start;
    logic q0;
    logic qm1;
    logic eqz;
    logic ldA;
    logic ldQ;
    logic ldM;
    logic clrA;
    logic clrQ;
    logic clrFF;
    logic ldFF;
    logic sftA;
    logic sftQ;
    logic addsub;
    logic decr;
    logic ldcnt;
    logic busy;
    logic done;

    modport slave (
        input  start, q0, qm1, eqz,
        output ldA, ldQ, ldM, clrA, clrQ, clrFF, ldFF,
               sftA, sftQ, addsub, decr, ldcnt, busy, done
    );

    modport master (
        output start, q0, qm1, eqz,
        input  ldA, ldQ, ldM, clrA, clrQ, clrFF, ldFF,
               sftA, sftQ, addsub, decr, ldcnt, busy, done
    );
endinterface

// File: rtl/booth_ctrl.sv
// Moore sequencer for a radix-2 Booth multiplier datapath.
// Every strobe is registered and is a pure decode of the current state.
module booth_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 5
) (
    input  logic         clk,
    input  logic         rst,
    booth_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADM = 3'd1,
        LOADQ = 3'd2,
        CHECK = 3'd3,
        ADD   = 3'd4,
        SUB   = 3'd5,
        SHIFT = 3'd6,
        DONE  = 3'd7
    } state_t;

    typedef struct packed {
        logic ldA;
        logic ldQ;
        logic ldM;
        logic clrA;
        logic clrQ;
        logic clrFF;
        logic ldFF;
        logic sftA;
        logic sftQ;
        logic addsub;
        logic decr;
        logic ldcnt;
        logic busy;
        logic done;
    } strobes_t;

    state_t   state_q, state_d;
    strobes_t outs_q, outs_d;

    if (CNTW < $clog2(WIDTH + 1)) begin : g_cntw_check
        $error("booth_ctrl: CNTW too narrow to hold WIDTH");
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.start) state_d = LOADM;
            LOADM: state_d = LOADQ;
            LOADQ: state_d = CHECK;
            CHECK: begin
                if (bus.eqz) begin
                    state_d = DONE;
                end else begin
                    case ({bus.q0, bus.qm1})
                        2'b10:   state_d = SUB;
                        2'b01:   state_d = ADD;
                        default: state_d = SHIFT;
                    endcase
                end
            end
            ADD:     state_d = SHIFT;
            SUB:     state_d = SHIFT;
            SHIFT:   state_d = CHECK;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decoding the next state lets the strobes sit in flops yet still track state_q exactly.
    always_comb begin
        outs_d = '0;
        case (state_d)
            LOADM: begin
                outs_d.ldM   = 1'b1;
                outs_d.clrA  = 1'b1;
                outs_d.clrFF = 1'b1;
                outs_d.busy  = 1'b1;
            end
            LOADQ: begin
                outs_d.ldQ   = 1'b1;
                outs_d.ldcnt = 1'b1;
                outs_d.busy  = 1'b1;
            end
            CHECK: outs_d.busy = 1'b1;
            ADD: begin
                outs_d.ldA    = 1'b1;
                outs_d.addsub = 1'b1;
                outs_d.busy   = 1'b1;
            end
            SUB: begin
                outs_d.ldA  = 1'b1;
                outs_d.busy = 1'b1;
            end
            SHIFT: begin
                outs_d.sftA = 1'b1;
                outs_d.sftQ = 1'b1;
                outs_d.ldFF = 1'b1;
                outs_d.decr = 1'b1;
                outs_d.busy = 1'b1;
            end
            DONE: begin
                outs_d.done = 1'b1;
                outs_d.busy = 1'b1;
            end
            default: outs_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            outs_q  <= '0;
        end else begin
            state_q <= state_d;
            outs_q  <= outs_d;
        end
    end

    assign bus.ldA    = outs_q.ldA;
    assign bus.ldQ    = outs_q.ldQ;
    assign bus.ldM    = outs_q.ldM;
    assign bus.clrA   = outs_q.clrA;
    assign bus.clrQ   = outs_q.clrQ;
    assign bus.clrFF  = outs_q.clrFF;
    assign bus.ldFF   = outs_q.ldFF;
    assign bus.sftA   = outs_q.sftA;
    assign bus.sftQ   = outs_q.sftQ;
    assign bus.addsub = outs_q.addsub;
    assign bus.decr   = outs_q.decr;
    assign bus.ldcnt  = outs_q.ldcnt;
    assign bus.busy   = outs_q.busy;
    assign bus.done   = outs_q.done;

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: drives a behavioural Booth datapath from the DUT strobes and checks
// every cycle against a state trace built from the multiplier's bit pairs.
module tb_booth_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    booth_ctrl_if bus();

    booth_ctrl #(.WIDTH(16), .CNTW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [13:0] V_LOADM = 14'b00110100000010;
    localparam logic [13:0] V_LOADQ = 14'b01000000000110;
    localparam logic [13:0] V_CHECK = 14'b00000000000010;
    localparam logic [13:0] V_ADD   = 14'b10000000010010;
    localparam logic [13:0] V_SUB   = 14'b10000000000010;
    localparam logic [13:0] V_SHIFT = 14'b00000011101010;
    localparam logic [13:0] V_DONE  = 14'b00000000000011;

    int nVec = 0;
    int nFail = 0;
    bit checkEn = 1'b0;

    logic [15:0] mcand, mplier, dataIn, regQ, regM;
    // A carries a guard bit so that (-2^15)*(-2^15) does not overflow the partial sum.
    logic [16:0] regA;
    logic        regFF;
    logic [4:0]  cnt;
    logic [13:0] dutVec;
    logic [13:0] expQ[$];

    int nShift, nLdA, nOps;
    int opIter[2];
    int opAdd[2];

    assign bus.q0  = regQ[0];
    assign bus.qm1 = regFF;
    assign bus.eqz = (cnt == 5'd0);
    assign dutVec = {bus.ldA, bus.ldQ, bus.ldM, bus.clrA, bus.clrQ, bus.clrFF, bus.ldFF,
                     bus.sftA, bus.sftQ, bus.addsub, bus.decr, bus.ldcnt, bus.busy, bus.done};

    always_comb dataIn = bus.ldM ? mcand : (bus.ldQ ? mplier : 16'h0000);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            regA <= '0; regQ <= '0; regM <= '0; regFF <= 1'b0; cnt <= '0;
        end else begin
            if (bus.ldM)   regM  <= dataIn;
            if (bus.ldQ)   regQ  <= dataIn;
            if (bus.clrA)  regA  <= '0;
            if (bus.clrFF) regFF <= 1'b0;
            if (bus.ldcnt) cnt   <= 5'd16;
            if (bus.ldA)   regA  <= bus.addsub ? regA + {regM[15], regM} : regA - {regM[15], regM};
            if (bus.sftA)  regA  <= {regA[16], regA[16:1]};
            if (bus.sftQ)  regQ  <= {regA[0], regQ[15:1]};
            if (bus.ldFF)  regFF <= regQ[0];
            if (bus.decr)  cnt   <= cnt - 5'd1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int modelOps(input logic [15:0] q);
        int n = 0;
        logic prev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (q[i] != prev) n++;
            prev = q[i];
        end
        return n;
    endfunction

    function automatic int modelLat(input logic [15:0] q);
        return 2 + 2 * 16 + modelOps(q) + 2;
    endfunction

    function automatic logic [31:0] modelProd(input logic [15:0] m, input logic [15:0] q);
        int p;
        p = int'($signed(m)) * int'($signed(q));
        return p;
    endfunction

    task automatic pushTrace(input logic [15:0] q);
        logic prev = 1'b0;
        expQ.push_back(V_LOADM);
        expQ.push_back(V_LOADQ);
        for (int i = 0; i < 16; i++) begin
            expQ.push_back(V_CHECK);
            if (q[i] && !prev) expQ.push_back(V_SUB);
            else if (!q[i] && prev) expQ.push_back(V_ADD);
            expQ.push_back(V_SHIFT);
            prev = q[i];
        end
        expQ.push_back(V_CHECK);
        expQ.push_back(V_DONE);
    endtask

    // Every cycle: the strobe word must match the next trace entry, or all-zero when idle.
    always @(negedge clk) begin : compareProc
        logic [13:0] e;
        if (checkEn) begin
            e = (expQ.size() > 0) ? expQ.pop_front() : 14'b0;
            checkOutput("strobes", {18'b0, dutVec}, {18'b0, e});
        end
    end

    task automatic applyStimulus(input logic [15:0] m, input logic [15:0] q);
        @(negedge clk);
        mcand = m;
        mplier = q;
        bus.start = 1'b1;
        @(posedge clk);
        pushTrace(q);
        #1 bus.start = 1'b0;
    endtask

    task automatic waitDone(input int firstK, input int pulseAt, output int lat, output logic [31:0] prod);
        lat = 0;
        prod = '0;
        nShift = 0; nLdA = 0; nOps = 0;
        for (int k = firstK; k <= firstK + 120; k++) begin
            @(negedge clk);
            if (pulseAt != 0) begin
                if (k == pulseAt) bus.start = 1'b1;
                else if (k == pulseAt + 1) bus.start = 1'b0;
            end
            if (bus.sftA) nShift++;
            if (bus.ldA) begin
                if (nOps < 2) begin
                    opIter[nOps] = nShift;
                    opAdd[nOps] = int'(bus.addsub);
                end
                nOps++;
                nLdA++;
            end
            if (bus.done) begin
                lat = k;
                prod = {regA[15:0], regQ};
                break;
            end
        end
        if (lat == 0) begin
            nVec++;
            nFail++;
            $display("[TB] FAIL done_timeout: got no done, expected done within 120 cycles");
        end
    endtask

    task automatic runMul(input logic [15:0] m, input logic [15:0] q, input int pulseAt,
                          output int lat, output logic [31:0] prod);
        applyStimulus(m, q);
        waitDone(1, pulseAt, lat, prod);
        checkOutput("model_latency", lat, modelLat(q));
        checkOutput("model_product", prod, modelProd(m, q));
        @(negedge clk);
        checkOutput("done_one_cycle", {31'b0, bus.done}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] prod;
        bit found;
        bus.start = 1'b0;
        mcand = '0;
        mplier = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", {18'b0, dutVec}, 32'd0);
        rst = 1'b0;
        checkEn = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] zero multiplier");
        runMul(16'h0003, 16'h0000, 0, lat, prod);
        checkOutput("zero_latency", lat, 32'd36);
        checkOutput("zero_product", prod, 32'h00000000);
        checkOutput("zero_shifts", nShift, 32'd16);
        checkOutput("zero_ldA", nLdA, 32'd0);

        $display("[TB] positive operands");
        runMul(16'h0007, 16'h0005, 0, lat, prod);
        checkOutput("pos_product", prod, 32'h00000023);
        checkOutput("pos_op1_iter", opIter[0], 32'd0);
        checkOutput("pos_op1_sub", opAdd[0], 32'd0);
        checkOutput("pos_op2_iter", opIter[1], 32'd1);
        checkOutput("pos_op2_add", opAdd[1], 32'd1);

        $display("[TB] signed operands");
        runMul(16'hFFFD, 16'h0006, 0, lat, prod);
        checkOutput("neg_product", prod, 32'hFFFFFFEE);
        runMul(16'h8000, 16'h8000, 0, lat, prod);
        checkOutput("min_product", prod, 32'h40000000);

        $display("[TB] worst-case latency");
        runMul(16'h0001, 16'h5555, 0, lat, prod);
        checkOutput("worst_latency", lat, 32'd52);
        checkOutput("worst_ops", nOps, 32'd16);
        checkOutput("worst_product", prod, 32'h00005555);

        $display("[TB] start pulsed while busy");
        runMul(16'h0002, 16'h0003, 5, lat, prod);
        checkOutput("busy_pulse_product", prod, 32'h00000006);

        $display("[TB] reset during ADD");
        applyStimulus(16'h0007, 16'h0005);
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.ldA && bus.addsub) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("reached_add", {31'b0, found}, 32'd1);
        #2 rst = 1'b1;
        expQ.delete();
        #1;
        checkOutput("midrst_outputs", {18'b0, dutVec}, 32'd0);
        checkOutput("midrst_busy", {31'b0, bus.busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        runMul(16'h0007, 16'h0005, 0, lat, prod);
        checkOutput("post_rst_product", prod, 32'h00000023);

        $display("[TB] start held across done");
        @(negedge clk);
        mcand = 16'h0003;
        mplier = 16'h0004;
        bus.start = 1'b1;
        @(posedge clk);
        pushTrace(16'h0004);
        waitDone(1, 0, lat, prod);
        checkOutput("b2b_first_latency", lat, 32'd38);
        checkOutput("b2b_first_product", prod, 32'h0000000C);
        mcand = 16'hFFFE;
        mplier = 16'h0009;
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b_idle_gap", {31'b0, bus.busy}, 32'd0);
        @(posedge clk);
        pushTrace(16'h0009);
        #1 bus.start = 1'b0;
        @(negedge clk);
        checkOutput("b2b_loadm_after_2", {31'b0, bus.ldM}, 32'd1);
        waitDone(2, 0, lat, prod);
        checkOutput("b2b_second_latency", lat, modelLat(16'h0009));
        checkOutput("b2b_second_product", prod, 32'hFFFFFFEE);
        @(negedge clk);
        checkOutput("b2b_done_one_cycle", {31'b0, bus.done}, 32'd0);

        repeat (3) @(negedge clk);
        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
